// File: rtl/sel_rr_sampler.sv
// Round-robin sampler for a 4-to-1 2-bit selector: picks a requester, settles SEL, samples MUX_IN.
// Optional O_READY timeout with DROP pulse is enabled by defining SEL_RR_TIMEOUT_EN.
module sel_rr_sampler #(
  parameter int HOLD_CYC = 2,
  parameter int TMO_CYC  = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic [1:0] MUX_IN,
  output logic [1:0] SEL,
  output logic [3:0] GNT,
  output logic       O_VALID,
  output logic [1:0] O_DATA,
  output logic [1:0] O_CH,
  input  logic       O_READY,
  output logic       DROP
);

  generate
    if (HOLD_CYC < 1 || HOLD_CYC > 15 || TMO_CYC < 2 || TMO_CYC > 255) begin : g_bad_param
      $error("sel_rr_sampler: HOLD_CYC or TMO_CYC out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [1:0] o_data_q, o_data_d;
  logic [1:0] o_ch_q, o_ch_d;
  logic       o_valid_q, o_valid_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] pick_ch;

`ifdef SEL_RR_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       drop_q, drop_d;
`endif

  // Search upward from last+1; descending loop lets the nearest hit win.
  always_comb begin
    pick_ch = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      if (REQ[2'(last_q + 2'(i))]) pick_ch = 2'(last_q + 2'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    o_data_d  = o_data_q;
    o_ch_d    = o_ch_q;
    o_valid_d = o_valid_q;
    gnt_d     = 4'b0000;
`ifdef SEL_RR_TIMEOUT_EN
    tmo_d     = tmo_q;
    drop_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          sel_d   = pick_ch;
          cnt_d   = 4'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(HOLD_CYC - 1)) begin
          o_data_d  = MUX_IN;
          o_ch_d    = sel_q;
          o_valid_d = 1'b1;
          gnt_d     = 4'b0001 << sel_q;
          state_d   = OUTPUT;
`ifdef SEL_RR_TIMEOUT_EN
          tmo_d     = 8'd0;
`endif
        end
      end
      OUTPUT: begin
        if (O_READY) begin
          last_d    = o_ch_q;
          o_valid_d = 1'b0;
          state_d   = IDLE;
        end
`ifdef SEL_RR_TIMEOUT_EN
        else if (tmo_q == 8'(TMO_CYC - 1)) begin
          last_d    = o_ch_q;
          o_valid_d = 1'b0;
          drop_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;
      o_data_q  <= 2'd0;
      o_ch_q    <= 2'd0;
      o_valid_q <= 1'b0;
      gnt_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      o_data_q  <= o_data_d;
      o_ch_q    <= o_ch_d;
      o_valid_q <= o_valid_d;
      gnt_q     <= gnt_d;
    end
  end

`ifdef SEL_RR_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_q  <= 8'd0;
      drop_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      drop_q <= drop_d;
    end
  end

  assign DROP = drop_q;
`else
  assign DROP = 1'b0;
`endif

  assign SEL     = sel_q;
  assign GNT     = gnt_q;
  assign O_VALID = o_valid_q;
  assign O_DATA  = o_data_q;
  assign O_CH    = o_ch_q;

endmodule

// File: tb/tb_sel_rr_sampler.sv
// Scoreboard bench for sel_rr_sampler: stimulus pushes expected samples, a negedge monitor checks them.
module tb_sel_rr_sampler;
  localparam int HOLD = 2;
`ifdef SEL_RR_TIMEOUT_EN
  localparam int TMO = 4;
  localparam int STALL_MAX = 3;
`else
  localparam int TMO = 16;
  localparam int STALL_MAX = 6;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [1:0] mux_in;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       o_valid;
  logic [1:0] o_data;
  logic [1:0] o_ch;
  logic       o_ready;
  logic       drop;

  logic [1:0] mux_data [4];
  assign mux_in = mux_data[sel];

  sel_rr_sampler #(.HOLD_CYC(HOLD), .TMO_CYC(TMO)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .MUX_IN(mux_in), .SEL(sel), .GNT(gnt),
    .O_VALID(o_valid), .O_DATA(o_data), .O_CH(o_ch), .O_READY(o_ready), .DROP(drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0] ch;
    logic [1:0] data;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  logic [1:0] last_m;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Round-robin reference: first requester at last+1, last+2, ... (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    for (int i = 1; i <= 4; i++) begin
      if (r[(last + i) % 4]) return 2'((last + i) % 4);
    end
    return 2'd0;
  endfunction

  // Monitor
  logic prev_valid = 1'b0;
  logic [1:0] cur_ch, cur_data;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (o_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_sample: got ch %0d data %0d, expected none", o_ch, o_data);
        end else begin
          e = exp_q.pop_front();
          chk("sample_ch", o_ch, e.ch);
          chk("sample_data", o_data, e.data);
          chk("sample_gnt", gnt, 4'b0001 << e.ch);
          chk("sample_latency", cyc, e.cyc);
          cur_ch = e.ch;
          cur_data = e.data;
        end
      end else if (o_valid) begin
        chk("hold_data", o_data, cur_data);
        chk("hold_ch", o_ch, cur_ch);
        chk("hold_sel", sel, cur_ch);
        chk("gnt_single", gnt, 0);
      end else begin
        chk("gnt_idle", gnt, 0);
      end
`ifndef SEL_RR_TIMEOUT_EN
      chk("drop_tied", drop, 0);
`endif
      prev_valid = o_valid;
    end
  end

  task automatic run_txn(input logic [3:0] r, input int stall);
    int n;
    logic [1:0] ch;
    ch = rr_pick(r, last_m);
    exp_q.push_back('{ch, mux_data[ch], cyc + 1 + HOLD});
    req = r;
    @(negedge clk);
    chk("sel_load", sel, ch);
    n = 0;
    while (!o_valid && n < 4 * HOLD + 8) begin
      req = 4'($urandom);
      o_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("valid_rise", o_valid, 1);
    req = 4'b0000;
    for (int k = 0; k < 4; k++) mux_data[k] = 2'($urandom);
    o_ready = 1'(stall == 0);
    repeat (stall) @(negedge clk);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    last_m = ch;
    chk("hs_clear", o_valid, 0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    req = 4'hf;
    o_ready = 1'b1;
    for (int k = 0; k < 4; k++) mux_data[k] = 2'd0;
    last_m = 2'd3;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_drop", drop, 0);
    o_ready = 1'b0;
    mux_data[2] = 2'b10;
    rst = 1'b0;
    run_txn(4'b0100, 0);

`ifndef SEL_RR_TIMEOUT_EN
    mux_data[1] = 2'b01;
    run_txn(4'b0010, 10);
`endif

    // Reset in the middle of SETTLE discards the sample
    req = 4'b0100;
    @(negedge clk);
    chk("mid_sel", sel, rr_pick(4'b0100, last_m));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_ch", o_ch, 0);
    chk("mid_rst_drop", drop, 0);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_m = 2'd3;
    mux_data[3] = 2'b11;
    run_txn(4'b1000, 0);

    // Four persistent requesters with a consumer that is always ready
    base = cyc + 1 + HOLD;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] ch;
      ch = rr_pick(4'hf, last_m);
      exp_q.push_back('{ch, mux_data[ch], base + k * (HOLD + 2)});
      last_m = ch;
    end
    req = 4'hf;
    o_ready = 1'b1;
    repeat (HOLD + 1 + 4 * (HOLD + 2)) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    o_ready = 1'b0;

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) mux_data[k] = 2'($urandom);
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, STALL_MAX));
    end

`ifdef SEL_RR_TIMEOUT_EN
    begin
      int n;
      logic [1:0] ch;
      ch = rr_pick(4'b0001, last_m);
      exp_q.push_back('{ch, mux_data[ch], cyc + 1 + HOLD});
      req = 4'b0001;
      o_ready = 1'b0;
      @(negedge clk);
      req = 4'b0000;
      n = 0;
      while (!o_valid && n < 4 * HOLD + 8) begin
        @(negedge clk);
        n++;
      end
      chk("tmo_valid_rise", o_valid, 1);
      repeat (TMO - 1) begin
        @(negedge clk);
        chk("tmo_hold", o_valid, 1);
        chk("tmo_nodrop", drop, 0);
      end
      @(negedge clk);
      chk("tmo_valid_clr", o_valid, 0);
      chk("tmo_drop_pulse", drop, 1);
      @(negedge clk);
      chk("tmo_drop_one", drop, 0);
      last_m = ch;
      run_txn(4'hf, 0);
    end
`endif

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending samples, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
